// File: rtl/conv1d_ctrl_fsm.sv
// Sequencing controller for a "valid" 1-D convolution engine: walks input/weight
// buffer addresses, issues MAC strobes and hands each output to the sink.
module conv1d_ctrl_fsm #(
  parameter int LEN_W = 10,
  parameter int KW    = 5,
  parameter int MAX_K = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic [LEN_W-1:0] in_len_i,
  input  logic [KW-1:0]    k_len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  output logic             rd_en_o,
  output logic [LEN_W-1:0] in_addr_o,
  output logic [KW-1:0]    w_addr_o,
  output logic             mac_en_o,
  output logic             mac_clr_o,
  output logic             mac_last_o,
  output logic             out_valid_o,
  output logic [LEN_W-1:0] out_addr_o,
  input  logic             out_ready_i
);

  // state   | meaning
  // S_IDLE  | waiting for start; config checked here
  // S_MAC   | issuing K buffer reads for output o
  // S_DRAIN | last tap in the MAC pipeline, no read
  // S_WRITE | result presented, waiting for out_ready_i
  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DRAIN, S_WRITE} state_t;

  state_t           r_state;
  logic [KW-1:0]    r_k_len;
  logic [LEN_W-1:0] r_last_o;
  logic             w_cfg_bad;
  logic             w_k_last;

  assign w_cfg_bad = (k_len_i == '0) || (int'(k_len_i) > MAX_K) ||
                     (LEN_W'(k_len_i) > in_len_i);
  assign w_k_last  = (w_addr_o == r_k_len - KW'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_k_len     <= '0;
      r_last_o    <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      error_o     <= 1'b0;
      rd_en_o     <= 1'b0;
      in_addr_o   <= '0;
      w_addr_o    <= '0;
      mac_en_o    <= 1'b0;
      mac_clr_o   <= 1'b0;
      mac_last_o  <= 1'b0;
      out_valid_o <= 1'b0;
      out_addr_o  <= '0;
    end else begin
      // strobes trail the read by the fixed 1-cycle buffer latency
      mac_en_o   <= rd_en_o;
      mac_clr_o  <= rd_en_o && (w_addr_o == '0);
      mac_last_o <= rd_en_o && w_k_last;
      rd_en_o    <= 1'b0;

      if (clear_i) begin
        done_o  <= 1'b0;
        error_o <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_k_len <= k_len_i;
            done_o  <= 1'b0;
            if (w_cfg_bad) begin
              error_o <= 1'b1;
            end else begin
              error_o    <= 1'b0;
              r_last_o   <= in_len_i - LEN_W'(k_len_i);
              busy_o     <= 1'b1;
              rd_en_o    <= 1'b1;
              in_addr_o  <= '0;
              w_addr_o   <= '0;
              out_addr_o <= '0;
              r_state    <= S_MAC;
            end
          end
        end
        S_MAC: begin
          if (w_k_last) begin
            r_state <= S_DRAIN;
          end else begin
            rd_en_o   <= 1'b1;
            in_addr_o <= in_addr_o + LEN_W'(1);
            w_addr_o  <= w_addr_o + KW'(1);
          end
        end
        S_DRAIN: begin
          out_valid_o <= 1'b1;
          r_state     <= S_WRITE;
        end
        S_WRITE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            if (out_addr_o == r_last_o) begin
              busy_o  <= 1'b0;
              done_o  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              out_addr_o <= out_addr_o + LEN_W'(1);
              in_addr_o  <= out_addr_o + LEN_W'(1);
              w_addr_o   <= '0;
              rd_en_o    <= 1'b1;
              r_state    <= S_MAC;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv1d_ctrl_fsm.sv
// Randomized bench for conv1d_ctrl_fsm; expectations come from a cycle-timing
// model of the convolution schedule (K reads, 1 drain, then the write).
module tb_conv1d_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic [9:0] in_len = '0;
  logic [4:0] k_len = '0;
  logic       out_ready = 1'b1;
  logic       busy, done, error, rd_en, mac_en, mac_clr, mac_last, out_valid;
  logic [9:0] in_addr, out_addr;
  logic [4:0] w_addr;

  int n_vec = 0;
  int n_err = 0;

  conv1d_ctrl_fsm dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear),
    .in_len_i(in_len), .k_len_i(k_len),
    .busy_o(busy), .done_o(done), .error_o(error),
    .rd_en_o(rd_en), .in_addr_o(in_addr), .w_addr_o(w_addr),
    .mac_en_o(mac_en), .mac_clr_o(mac_clr), .mac_last_o(mac_last),
    .out_valid_o(out_valid), .out_addr_o(out_addr), .out_ready_i(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [33:0] all_outs();
    return {busy, done, error, rd_en, in_addr, w_addr, mac_en, mac_clr, mac_last,
            out_valid, out_addr};
  endfunction

  // One run. ready_pct: chance out_ready is high per WRITE cycle.
  // stall_o: hold ready low 7 cycles when output stall_o is presented.
  // stray: pulse start+clear with a different config in MAC.
  // rst_o: assert reset during MAC of that output and abandon the run.
  task automatic run(input int n, input int k, input int ready_pct,
                     input int stall_o, input bit stray, input int rst_o);
    int  cur_o = 0, last_evt = 0, fin = -1, stall_cnt = 0;
    bit  prev_rd = 0, rd_exp, valid_exp, rdy;
    int  prev_k = 0, kk = 0;
    @(negedge clk);
    in_len = 10'(n); k_len = 5'(k); start = 1'b1; out_ready = 1'b1;
    for (int t = 1; t < 5000; t++) begin
      @(negedge clk);
      start = 1'b0; clear = 1'b0;
      if (t == 3) begin in_len = 10'(n); k_len = 5'(k); end
      rd_exp    = (fin < 0) && (t > last_evt) && (t <= last_evt + k);
      kk        = t - last_evt - 1;
      valid_exp = (fin < 0) && (t >= last_evt + k + 2);
      chk("rd_en", rd_en, rd_exp);
      if (rd_exp) chk("rd_addr", {in_addr, w_addr}, {10'(cur_o + kk), 5'(kk)});
      chk("mac", {mac_en, mac_clr, mac_last},
          {prev_rd, prev_rd && prev_k == 0, prev_rd && prev_k == k - 1});
      chk("out_valid", out_valid, valid_exp);
      if (valid_exp) chk("out_addr", out_addr, 10'(cur_o));
      chk("busy", busy, (fin < 0) || (t <= fin));
      chk("flags", {done, error}, {(fin >= 0) && (t > fin), 1'b0});
      prev_rd = rd_exp; prev_k = kk;
      if (fin >= 0) return;
      if (stray && t == 2) begin
        start = 1'b1; clear = 1'b1; in_len = 10'(n + 3); k_len = 5'd1;
      end
      if (rst_o >= 0 && cur_o == rst_o && rd_exp && kk == 1) begin
        rst = 1'b1;
        @(negedge clk);
        chk("rst_midrun", all_outs(), '0);
        rst = 1'b0;
        return;
      end
      rdy = ($urandom_range(99) < ready_pct);
      if (valid_exp && cur_o == stall_o && stall_cnt < 7) begin
        rdy = 1'b0; stall_cnt++;
      end
      out_ready = rdy;
      if (valid_exp && rdy) begin
        if (cur_o == n - k) fin = t;
        else begin cur_o++; last_evt = t; end
      end
    end
    chk("timeout", 1, 0);
  endtask

  task automatic bad(input int n, input int k, input bit with_clear);
    @(negedge clk);
    in_len = 10'(n); k_len = 5'(k); start = 1'b1; clear = with_clear;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      start = 1'b0; clear = 1'b0;
      chk("bad_idle", {busy, rd_en, mac_en, out_valid}, 4'b0);
    end
    chk("bad_flags", {done, error}, 2'b01);
  endtask

  initial begin
    int n, k;
    repeat (3) @(negedge clk);
    chk("reset", all_outs(), '0);
    rst = 1'b0;

    run(8, 3, 100, -1, 0, -1);
    bad(8, 0, 0);
    bad(8, 9, 0);
    bad(8, 17, 0);
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    chk("clear_err", {done, error}, 2'b00);

    run(4, 4, 100, -1, 0, -1);
    run(5, 1, 100, -1, 0, -1);
    run(8, 3, 100, 2, 0, -1);
    bad(8, 0, 1);
    run(8, 3, 100, -1, 1, 3);
    @(negedge clk);
    chk("after_rst", all_outs(), '0);
    run(8, 3, 100, -1, 0, -1);
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    chk("clear_done", {done, error}, 2'b00);

    for (int i = 0; i < 12; i++) begin
      n = $urandom_range(24, 1);
      k = $urandom_range((n < 16) ? n : 16, 1);
      run(n, k, $urandom_range(100, 40), $urandom_range(3, 0), i[0], -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
